audio_sram_sequencer: RTL
=========================

AUDIO_SRAM_SEQUENCER -- requirements
Module: audio_sram_sequencer

Interface
REQ-001 Parameter: ADDR_W, 18, SRAM word-address width (256K x 16 SRAM).
REQ-002 Port: clk  in  1  system clock; all logic SHALL be on its rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: key_record  in  1  one-cycle request pulse to start recording.
REQ-005 Port: key_play  in  1  one-cycle request pulse to start playback.
REQ-006 Port: key_stop  in  1  one-cycle request pulse to stop the current operation.
REQ-007 Port: adc_ready  in  1  one-cycle strobe: captured ADC sample is valid.
REQ-008 Port: adc_data  in  16  ADC sample from the audio interface.
REQ-009 Port: dac_req  in  1  one-cycle strobe: audio interface needs the next DAC sample.
REQ-010 Port: sram_rdata  in  16  SRAM read data, valid one cycle after sram_oe.
REQ-011 Port: sram_addr  out  ADDR_W  SRAM word address.
REQ-012 Port: sram_wdata  out  16  SRAM write data.
REQ-013 Port: sram_we  out  1  SRAM write enable, active-high, one cycle per word.
REQ-014 Port: sram_oe  out  1  SRAM read enable, active-high, one cycle per word.
REQ-015 Port: record  out  1  high in RECORD; drives the audio interface record input.
REQ-016 Port: play  out  1  high in PLAY; drives the audio interface play input.
REQ-017 Port: dac_data  out  16  sample to the audio interface; held until the next update.
REQ-018 Port: dac_valid  out  1  one-cycle pulse when dac_data updates.
REQ-019 Port: mem_full  out  1  high after a recording ends by filling memory; cleared on the next record start.
REQ-020 Port: state  out  2  current state encoding.

Function
REQ-021 States SHALL be IDLE=00, RECORD=01, PLAY=10, FETCH=11. FETCH is the playback read-wait state.
REQ-022 Key priority in the same cycle SHALL be: stop > record > play.
REQ-023 IDLE + key_record SHALL go to RECORD, set wr_ptr=0 and clear mem_full.
REQ-024 IDLE + key_play SHALL go to PLAY with rd_ptr=0 only if end_addr!=0; otherwise it SHALL stay in IDLE.
REQ-025 Outside IDLE, key_record and key_play SHALL be ignored.
REQ-026 key_stop in any non-IDLE state SHALL return to IDLE on the next cycle. An in-flight FETCH SHALL be discarded, with no dac_valid pulse.
REQ-027 Stopping a recording SHALL set end_addr=wr_ptr, the count of words written.
REQ-028 RECORD + adc_ready at cycle N SHALL assert sram_we=1, sram_addr=wr_ptr and sram_wdata=adc_data at cycle N+1 for exactly one cycle; wr_ptr SHALL then increment.
REQ-029 A write to address 2^ADDR_W-1 SHALL end the recording:
- end_addr = 0 (wrapped count)
- mem_full = 1
- state -> IDLE
REQ-030 When mem_full=1, a full-memory playback SHALL treat end_addr=0 as 2^ADDR_W words.
REQ-031 PLAY + dac_req at cycle N SHALL assert sram_oe=1 and sram_addr=rd_ptr at cycle N+1, then enter FETCH.
REQ-032 FETCH at cycle N+2 SHALL latch sram_rdata into dac_data, pulse dac_valid, increment rd_ptr and return to PLAY.
REQ-033 dac_req arriving in FETCH SHALL be ignored.
REQ-034 When the incremented rd_ptr equals end_addr, playback SHALL go to IDLE; looping behaviour is defined by the LOOP_PLAY_EN configuration below.
REQ-035 sram_we and sram_oe SHALL never be high in the same cycle.
REQ-036 adc_ready outside RECORD and dac_req outside PLAY SHALL have no effect.

Reset
REQ-037 Reset SHALL set the following, overriding all inputs in that cycle:
- state=IDLE
- wr_ptr=0, rd_ptr=0, end_addr=0
- sram_addr=0, sram_wdata=0, sram_we=0, sram_oe=0
- dac_data=0, dac_valid=0
- mem_full=0, record=0, play=0
REQ-038 Reset during RECORD or PLAY SHALL abort with no further SRAM access, and the recording SHALL be lost.

Configuration
REQ-039 Macro AUDIO_SEQ_LOOP_PLAY_EN defined: on reaching end_addr, rd_ptr SHALL wrap to 0 and playback SHALL continue until key_stop.
REQ-040 Macro AUDIO_SEQ_LOOP_PLAY_EN undefined: playback SHALL stop in IDLE on reaching end_addr.

Structure
REQ-041 The state encodings and the default ADDR_W SHALL live in a shared package, audio_pkg.
REQ-042 One sub-module, audio_addr_ctr, SHALL implement the pointer with clear, increment and a terminal-count flag, instantiated once each for wr_ptr and rd_ptr.

Verification
REQ-043 Record: key_record, then 3 adc_ready with 0x1111/0x2222/0x3333, then key_stop.
- Expect writes to addresses 0/1/2, each one cycle after its strobe.
- Expect end_addr=3.
REQ-044 Play after REQ-043: 4 dac_req.
- Expect dac_data 0x1111, 0x2222, 0x3333, each with dac_valid two cycles after its dac_req.
- Expect IDLE after the third sample; the fourth dac_req has no effect (loop off).
- Loop on: expect the fourth output to be 0x1111.
REQ-045 key_play from reset (end_addr=0) -> state stays 00 and no sram_oe.
REQ-046 key_stop, key_record and key_play in the same cycle from RECORD -> IDLE next cycle.
REQ-047 ADDR_W=4: 16 adc_ready -> mem_full=1 and IDLE after the write to address 15; key_play then plays 16 words.
REQ-048 Reset asserted in FETCH -> no dac_valid, and all outputs at their reset values the next cycle.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared definitions for the audio SRAM sequencer.
//   state_e        : sequencer state encoding (also driven on the state port)
//   ADDR_W_DEFAULT : default SRAM word-address width (256K x 16 part)
package audio_pkg;

    localparam int ADDR_W_DEFAULT = 18;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RECORD = 2'b01,
        ST_PLAY   = 2'b10,
        ST_FETCH  = 2'b11
    } state_e;

endpackage

// File: rtl/audio_addr_ctr.sv
// SRAM word pointer with synchronous clear and increment.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   clr        : load zero (wins over inc)
//   inc        : advance by one, wrapping at 2^W
//   tc_value   : compare value for the terminal-count flag
//   count      : current pointer value
//   tc         : high while count equals tc_value
module audio_addr_ctr
    import audio_pkg::*;
#(
    parameter int W = ADDR_W_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] tc_value,
    output logic [W-1:0] count,
    output logic         tc
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tc    = (count_q == tc_value);

endmodule

// File: rtl/audio_sram_sequencer.sv
// Record/playback sequencer between an audio codec interface and a 16-bit SRAM.
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   key_record/play/stop  : one-cycle request pulses (stop > record > play)
//   adc_ready, adc_data   : captured sample strobe and data (used in RECORD)
//   dac_req               : next playback sample request (used in PLAY)
//   sram_rdata            : SRAM read data, valid the cycle after sram_oe
//   sram_addr/wdata/we/oe : SRAM word interface, one-cycle we/oe strobes
//   record, play          : mode outputs to the audio interface
//   dac_data, dac_valid   : playback sample and its one-cycle update pulse
//   mem_full              : last recording ended by filling the SRAM
//   state                 : current state encoding
// Build option: define AUDIO_SEQ_LOOP_PLAY_EN to loop playback from address 0
// until key_stop instead of stopping at the end of the recording.
//
// state  | meaning
// IDLE   | waiting for key_record / key_play
// RECORD | writing each adc_ready sample at wr_ptr
// PLAY   | waiting for dac_req
// FETCH  | SRAM read in flight; two cycles (read issued, then data latched)
module audio_sram_sequencer
    import audio_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_record,
    input  logic              key_play,
    input  logic              key_stop,
    input  logic              adc_ready,
    input  logic [15:0]       adc_data,
    input  logic              dac_req,
    input  logic [15:0]       sram_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_wdata,
    output logic              sram_we,
    output logic              sram_oe,
    output logic              record,
    output logic              play,
    output logic [15:0]       dac_data,
    output logic              dac_valid,
    output logic              mem_full,
    output logic [1:0]        state
);

    state_e            state_q, state_d;
    logic              rdata_due_q, rdata_due_d;
    logic [ADDR_W-1:0] end_addr_q, end_addr_d;
    logic              mem_full_q, mem_full_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [15:0]       sram_wdata_q, sram_wdata_d;
    logic              sram_we_q, sram_we_d;
    logic              sram_oe_q, sram_oe_d;
    logic [15:0]       dac_data_q, dac_data_d;
    logic              dac_valid_q, dac_valid_d;
    logic              record_q, record_d;
    logic              play_q, play_d;

    logic              wr_clr, wr_inc, wr_tc;
    logic              rd_clr, rd_inc, rd_tc;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W-1:0] rd_last;

    // Playback ends on the word before end_addr. end_addr==0 after a full
    // recording means 2^ADDR_W words, and the wrapped subtraction gives the
    // top address in exactly that case.
    assign rd_last = end_addr_q - ADDR_W'(1);

    audio_addr_ctr #(.W(ADDR_W)) u_wr_ctr (
        .clk      (clk),
        .reset    (reset),
        .clr      (wr_clr),
        .inc      (wr_inc),
        .tc_value ({ADDR_W{1'b1}}),
        .count    (wr_ptr),
        .tc       (wr_tc)
    );

    audio_addr_ctr #(.W(ADDR_W)) u_rd_ctr (
        .clk      (clk),
        .reset    (reset),
        .clr      (rd_clr),
        .inc      (rd_inc),
        .tc_value (rd_last),
        .count    (rd_ptr),
        .tc       (rd_tc)
    );

    always_comb begin
        state_d      = state_q;
        rdata_due_d  = 1'b0;
        end_addr_d   = end_addr_q;
        mem_full_d   = mem_full_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        sram_we_d    = 1'b0;
        sram_oe_d    = 1'b0;
        dac_data_d   = dac_data_q;
        dac_valid_d  = 1'b0;
        wr_clr       = 1'b0;
        wr_inc       = 1'b0;
        rd_clr       = 1'b0;
        rd_inc       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A simultaneous stop outranks the start requests.
                if (!key_stop) begin
                    if (key_record) begin
                        state_d    = ST_RECORD;
                        wr_clr     = 1'b1;
                        mem_full_d = 1'b0;
                    end else if (key_play && (end_addr_q != '0 || mem_full_q)) begin
                        state_d = ST_PLAY;
                        rd_clr  = 1'b1;
                    end
                end
            end
            ST_RECORD: begin
                if (key_stop) begin
                    end_addr_d = wr_ptr;
                    state_d    = ST_IDLE;
                end else if (adc_ready) begin
                    sram_we_d    = 1'b1;
                    sram_addr_d  = wr_ptr;
                    sram_wdata_d = adc_data;
                    wr_inc       = 1'b1;
                    if (wr_tc) begin
                        end_addr_d = '0;
                        mem_full_d = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_PLAY: begin
                if (key_stop) begin
                    state_d = ST_IDLE;
                end else if (dac_req) begin
                    sram_oe_d   = 1'b1;
                    sram_addr_d = rd_ptr;
                    state_d     = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (key_stop) begin
                    state_d = ST_IDLE;
                end else if (!rdata_due_q) begin
                    rdata_due_d = 1'b1;
                end else begin
                    dac_data_d  = sram_rdata;
                    dac_valid_d = 1'b1;
                    rd_inc      = 1'b1;
                    state_d     = ST_PLAY;
                    if (rd_tc) begin
`ifdef AUDIO_SEQ_LOOP_PLAY_EN
                        rd_clr  = 1'b1;
`else
                        state_d = ST_IDLE;
`endif
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // play stays high across the read-wait so the codec sees one session.
        record_d = (state_d == ST_RECORD);
        play_d   = (state_d == ST_PLAY) || (state_d == ST_FETCH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rdata_due_q  <= 1'b0;
            end_addr_q   <= '0;
            mem_full_q   <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            sram_we_q    <= 1'b0;
            sram_oe_q    <= 1'b0;
            dac_data_q   <= '0;
            dac_valid_q  <= 1'b0;
            record_q     <= 1'b0;
            play_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rdata_due_q  <= rdata_due_d;
            end_addr_q   <= end_addr_d;
            mem_full_q   <= mem_full_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            sram_we_q    <= sram_we_d;
            sram_oe_q    <= sram_oe_d;
            dac_data_q   <= dac_data_d;
            dac_valid_q  <= dac_valid_d;
            record_q     <= record_d;
            play_q       <= play_d;
        end
    end

    assign state      = state_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
    assign sram_we    = sram_we_q;
    assign sram_oe    = sram_oe_q;
    assign dac_data   = dac_data_q;
    assign dac_valid  = dac_valid_q;
    assign mem_full   = mem_full_q;
    assign record     = record_q;
    assign play       = play_q;

endmodule
